// File: rtl/kv_pkg.sv
// Shared constants for the key-value store Wishbone initiator: register map,
// opcodes, STATUS bit positions and the sequencer state encoding.
package kv_pkg;

    localparam logic [31:0] KV_KEY_OFS  = 32'h0;
    localparam logic [31:0] KV_VAL_OFS  = 32'h4;
    localparam logic [31:0] KV_CMD_OFS  = 32'h8;
    localparam logic [31:0] KV_STAT_OFS = 32'hC;

    localparam logic [1:0] KV_OP_PUT = 2'd1;
    localparam logic [1:0] KV_OP_GET = 2'd2;

    localparam int KV_STAT_BUSY_BIT  = 0;
    localparam int KV_STAT_FOUND_BIT = 1;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WR_KEY,
        ST_WR_VAL,
        ST_WR_CMD,
        ST_RD_STAT,
        ST_RD_VAL,
        ST_RESP
    } kv_state_e;

    function automatic logic kv_op_legal(input logic [1:0] op);
        return (op == KV_OP_PUT) || (op == KV_OP_GET);
    endfunction

endpackage

// File: rtl/kv_wb_initiator_if.sv
// Wishbone classic bus between the initiator and the store's responder port.
interface kv_wb_initiator_if;
    logic        wbm_cyc_o;
    logic        wbm_stb_o;
    logic        wbm_we_o;
    logic [3:0]  wbm_sel_o;
    logic [31:0] wbm_adr_o;
    logic [31:0] wbm_dat_o;
    logic [31:0] wbm_dat_i;
    logic        wbm_ack_i;

    modport master (
        output wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_sel_o, wbm_adr_o, wbm_dat_o,
        input  wbm_dat_i, wbm_ack_i
    );

    modport slave (
        input  wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_sel_o, wbm_adr_o, wbm_dat_o,
        output wbm_dat_i, wbm_ack_i
    );
endinterface

// File: rtl/kv_wb_cycle.sv
// Single Wishbone classic cycle engine: starts on req_i, holds the bus until ack
// or timeout, then pulses done_o for one cycle with err_o/rdata_o valid.
module kv_wb_cycle #(
    parameter int ACK_TIMEOUT = 15
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_i,
    input  logic        req_i,
    input  logic        we_i,
    input  logic [31:0] adr_i,
    input  logic [31:0] dat_i,
    output logic        done_o,
    output logic        err_o,
    output logic [31:0] rdata_o,
    kv_wb_initiator_if.master wbm
);
    localparam logic [3:0] WAIT_LAST = 4'(ACK_TIMEOUT - 1);

    logic        cyc_q, cyc_d;
    logic        we_q, we_d;
    logic [3:0]  sel_q, sel_d;
    logic [31:0] adr_q, adr_d;
    logic [31:0] dat_q, dat_d;
    logic [3:0]  wait_q, wait_d;
    logic        done_q, done_d;
    logic        err_q, err_d;
    logic [31:0] rdata_q, rdata_d;

    always_comb begin
        cyc_d   = cyc_q;
        we_d    = we_q;
        sel_d   = sel_q;
        adr_d   = adr_q;
        dat_d   = dat_q;
        wait_d  = wait_q;
        done_d  = 1'b0;
        err_d   = err_q;
        rdata_d = rdata_q;
        if (cyc_q) begin
            // Ack wins over a timeout landing in the same cycle
            if (wbm.wbm_ack_i) begin
                cyc_d   = 1'b0;
                sel_d   = 4'h0;
                done_d  = 1'b1;
                err_d   = 1'b0;
                rdata_d = wbm.wbm_dat_i;
            end else if (wait_q >= WAIT_LAST) begin
                cyc_d  = 1'b0;
                sel_d  = 4'h0;
                done_d = 1'b1;
                err_d  = 1'b1;
            end else begin
                wait_d = wait_q + 4'd1;
            end
        end else if (req_i) begin
            cyc_d  = 1'b1;
            sel_d  = 4'hF;
            we_d   = we_i;
            adr_d  = adr_i;
            dat_d  = dat_i;
            wait_d = 4'd0;
            err_d  = 1'b0;
        end
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            cyc_q   <= 1'b0;
            we_q    <= 1'b0;
            sel_q   <= 4'h0;
            adr_q   <= 32'h0;
            dat_q   <= 32'h0;
            wait_q  <= 4'd0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            rdata_q <= 32'h0;
        end else begin
            cyc_q   <= cyc_d;
            we_q    <= we_d;
            sel_q   <= sel_d;
            adr_q   <= adr_d;
            dat_q   <= dat_d;
            wait_q  <= wait_d;
            done_q  <= done_d;
            err_q   <= err_d;
            rdata_q <= rdata_d;
        end
    end

    assign wbm.wbm_cyc_o = cyc_q;
    assign wbm.wbm_stb_o = cyc_q;
    assign wbm.wbm_we_o  = we_q;
    assign wbm.wbm_sel_o = sel_q;
    assign wbm.wbm_adr_o = adr_q;
    assign wbm.wbm_dat_o = dat_q;
    assign done_o        = done_q;
    assign err_o         = err_q;
    assign rdata_o       = rdata_q;
endmodule

// File: rtl/kv_wb_initiator.sv
// Turns one PUT/GET command into the store's KEY/VALUE/CMD/STATUS register
// sequence over Wishbone, polls STATUS, and returns a single response.
module kv_wb_initiator
    import kv_pkg::*;
#(
    parameter logic [31:0] BASE_ADR    = 32'h3000_0000,
    parameter int          KEY_W       = 8,
    parameter int          POLL_MAX    = 255,
    parameter int          ACK_TIMEOUT = 15
) (
    input  logic             wb_clk_i,
    input  logic             wb_rst_i,
    input  logic             cmd_valid_i,
    output logic             cmd_ready_o,
    input  logic [1:0]       cmd_op_i,
    input  logic [KEY_W-1:0] cmd_key_i,
    input  logic [31:0]      cmd_val_i,
    output logic             rsp_valid_o,
    input  logic             rsp_ready_i,
    output logic             rsp_found_o,
    output logic             rsp_err_o,
    output logic [31:0]      rsp_val_o,
    kv_wb_initiator_if.master wbm
);
    localparam int              POLL_W    = $clog2(POLL_MAX + 1);
    localparam logic [POLL_W-1:0] POLL_LAST = POLL_W'(POLL_MAX - 1);

    kv_state_e         state_q, state_d;
    logic [1:0]        op_q, op_d;
    logic [KEY_W-1:0]  key_q, key_d;
    logic [31:0]       val_q, val_d;
    logic [POLL_W-1:0] poll_q, poll_d;
    logic              ready_q, ready_d;
    logic              rsp_valid_q, rsp_valid_d;
    logic              rsp_found_q, rsp_found_d;
    logic              rsp_err_q, rsp_err_d;
    logic [31:0]       rsp_val_q, rsp_val_d;

    logic              start;
    logic              bus_req, bus_we;
    logic [31:0]       bus_adr, bus_dat;
    logic              cyc_done, cyc_err;
    logic [31:0]       cyc_rdata;

    always_comb begin
        state_d     = state_q;
        op_d        = op_q;
        key_d       = key_q;
        val_d       = val_q;
        poll_d      = poll_q;
        ready_d     = ready_q;
        rsp_valid_d = rsp_valid_q;
        rsp_found_d = rsp_found_q;
        rsp_err_d   = rsp_err_q;
        rsp_val_d   = rsp_val_q;
        start       = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (cmd_valid_i && ready_q) begin
                    op_d        = cmd_op_i;
                    key_d       = cmd_key_i;
                    val_d       = cmd_val_i;
                    poll_d      = '0;
                    ready_d     = 1'b0;
                    rsp_found_d = 1'b0;
                    rsp_err_d   = 1'b0;
                    rsp_val_d   = 32'h0;
                    if (kv_op_legal(cmd_op_i)) begin
                        state_d = ST_WR_KEY;
                        start   = 1'b1;
                    end else begin
                        state_d     = ST_RESP;
                        rsp_valid_d = 1'b1;
                        rsp_err_d   = 1'b1;
                    end
                end
            end
            ST_WR_KEY, ST_WR_VAL, ST_WR_CMD, ST_RD_STAT, ST_RD_VAL: begin
                if (cyc_done) begin
                    start = 1'b1;
                    if (cyc_err) begin
                        state_d     = ST_RESP;
                        rsp_err_d   = 1'b1;
                        rsp_found_d = 1'b0;
                        rsp_val_d   = 32'h0;
                    end else begin
                        unique case (state_q)
                            ST_WR_KEY:  state_d = (op_q == KV_OP_PUT) ? ST_WR_VAL : ST_WR_CMD;
                            ST_WR_VAL:  state_d = ST_WR_CMD;
                            ST_WR_CMD:  state_d = ST_RD_STAT;
                            ST_RD_STAT: begin
                                // Busy re-reads STATUS (start stays set); poll count bounds it
                                if (cyc_rdata[KV_STAT_BUSY_BIT]) begin
                                    if (poll_q == POLL_LAST) begin
                                        state_d   = ST_RESP;
                                        rsp_err_d = 1'b1;
                                    end else begin
                                        poll_d = poll_q + 1'b1;
                                    end
                                end else if (op_q == KV_OP_GET && cyc_rdata[KV_STAT_FOUND_BIT]) begin
                                    state_d     = ST_RD_VAL;
                                    rsp_found_d = 1'b1;
                                end else begin
                                    state_d = ST_RESP;
                                end
                            end
                            ST_RD_VAL: begin
                                rsp_val_d = cyc_rdata;
                                state_d   = ST_RESP;
                            end
                            default: ;
                        endcase
                    end
                    rsp_valid_d = (state_d == ST_RESP);
                end
            end
            ST_RESP: begin
                if (rsp_ready_i) begin
                    state_d     = ST_IDLE;
                    rsp_valid_d = 1'b0;
                    rsp_found_d = 1'b0;
                    rsp_err_d   = 1'b0;
                    rsp_val_d   = 32'h0;
                    ready_d     = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // Bus request is issued on the same edge that enters a bus state
        bus_req = 1'b0;
        bus_we  = 1'b0;
        bus_adr = BASE_ADR;
        bus_dat = 32'h0;
        if (start) begin
            unique case (state_d)
                ST_WR_KEY: begin
                    bus_req = 1'b1;
                    bus_we  = 1'b1;
                    bus_adr = BASE_ADR + KV_KEY_OFS;
                    bus_dat = 32'(key_d);
                end
                ST_WR_VAL: begin
                    bus_req = 1'b1;
                    bus_we  = 1'b1;
                    bus_adr = BASE_ADR + KV_VAL_OFS;
                    bus_dat = val_d;
                end
                ST_WR_CMD: begin
                    bus_req = 1'b1;
                    bus_we  = 1'b1;
                    bus_adr = BASE_ADR + KV_CMD_OFS;
                    bus_dat = {30'h0, op_d};
                end
                ST_RD_STAT: begin
                    bus_req = 1'b1;
                    bus_adr = BASE_ADR + KV_STAT_OFS;
                end
                ST_RD_VAL: begin
                    bus_req = 1'b1;
                    bus_adr = BASE_ADR + KV_VAL_OFS;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state_q     <= ST_IDLE;
            op_q        <= 2'd0;
            key_q       <= '0;
            val_q       <= 32'h0;
            poll_q      <= '0;
            ready_q     <= 1'b1;
            rsp_valid_q <= 1'b0;
            rsp_found_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_val_q   <= 32'h0;
        end else begin
            state_q     <= state_d;
            op_q        <= op_d;
            key_q       <= key_d;
            val_q       <= val_d;
            poll_q      <= poll_d;
            ready_q     <= ready_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_found_q <= rsp_found_d;
            rsp_err_q   <= rsp_err_d;
            rsp_val_q   <= rsp_val_d;
        end
    end

    kv_wb_cycle #(
        .ACK_TIMEOUT (ACK_TIMEOUT)
    ) u_cycle (
        .wb_clk_i (wb_clk_i),
        .wb_rst_i (wb_rst_i),
        .req_i    (bus_req),
        .we_i     (bus_we),
        .adr_i    (bus_adr),
        .dat_i    (bus_dat),
        .done_o   (cyc_done),
        .err_o    (cyc_err),
        .rdata_o  (cyc_rdata),
        .wbm      (wbm)
    );

    assign cmd_ready_o = ready_q;
    assign rsp_valid_o = rsp_valid_q;
    assign rsp_found_o = rsp_found_q;
    assign rsp_err_o   = rsp_err_q;
    assign rsp_val_o   = rsp_val_q;
endmodule

// File: tb/tb_kv_wb_initiator.sv
// Bench for kv_wb_initiator: behavioural KV-store responder plus a
// command-level model of the expected bus traffic and responses.
module tb_kv_wb_initiator;
    localparam logic [31:0] BASE     = 32'h3000_0000;
    localparam int          POLL_MAX = 255;
    localparam int          ACK_TMO  = 15;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [1:0]  cmd_op = 2'd0;
    logic [7:0]  cmd_key = 8'h0;
    logic [31:0] cmd_val = 32'h0;
    logic        rsp_valid, rsp_found, rsp_err;
    logic        rsp_ready = 1'b0;
    logic [31:0] rsp_val;

    int n_chk = 0;
    int n_err = 0;

    kv_wb_initiator_if bus();

    kv_wb_initiator #(
        .BASE_ADR    (BASE),
        .KEY_W       (8),
        .POLL_MAX    (POLL_MAX),
        .ACK_TIMEOUT (ACK_TMO)
    ) dut (
        .wb_clk_i    (clk),
        .wb_rst_i    (rst),
        .cmd_valid_i (cmd_valid),
        .cmd_ready_o (cmd_ready),
        .cmd_op_i    (cmd_op),
        .cmd_key_i   (cmd_key),
        .cmd_val_i   (cmd_val),
        .rsp_valid_o (rsp_valid),
        .rsp_ready_i (rsp_ready),
        .rsp_found_o (rsp_found),
        .rsp_err_o   (rsp_err),
        .rsp_val_o   (rsp_val),
        .wbm         (bus)
    );

    always #5 clk = ~clk;

    // Responder: a tiny KV store with programmable busy time
    logic        no_ack = 1'b0, stuck = 1'b0, stray = 1'b0;
    int          busy_n = 0;
    int          stat_cnt = 0;
    int          cyc_cnt = 0;
    logic [7:0]  key_r = 8'h0;
    logic [31:0] val_r = 32'h0, rdv_r = 32'h0, rdat;
    logic        hit_r = 1'b0;
    logic [31:0] st_v [256];
    logic [255:0] st_ok = '0;
    logic [64:0] log_q [$];
    logic [31:0] ofs;

    assign ofs = bus.wbm_adr_o - BASE;
    assign bus.wbm_ack_i = (bus.wbm_cyc_o & bus.wbm_stb_o & ~no_ack) | stray;
    assign bus.wbm_dat_i = rdat;

    always_comb begin
        rdat = 32'h0;
        if (ofs == 32'hC) rdat = {30'h0, hit_r, stuck || (stat_cnt < busy_n)};
        else if (ofs == 32'h4) rdat = rdv_r;
    end

    always @(posedge clk) begin
        if (bus.wbm_cyc_o) cyc_cnt <= cyc_cnt + 1;
        if (bus.wbm_cyc_o && bus.wbm_ack_i) begin
            log_q.push_back({bus.wbm_we_o, bus.wbm_adr_o, bus.wbm_we_o ? bus.wbm_dat_o : 32'h0});
            if (bus.wbm_we_o) begin
                if (ofs == 32'h0) key_r <= bus.wbm_dat_o[7:0];
                else if (ofs == 32'h4) val_r <= bus.wbm_dat_o;
                else if (ofs == 32'h8) begin
                    stat_cnt <= 0;
                    if (bus.wbm_dat_o == 32'd1) begin
                        st_v[key_r]  <= val_r;
                        st_ok[key_r] <= 1'b1;
                    end else begin
                        hit_r <= st_ok[key_r];
                        rdv_r <= st_ok[key_r] ? st_v[key_r] : 32'h0;
                    end
                end
            end else if (ofs == 32'hC) begin
                stat_cnt <= stat_cnt + 1;
            end
        end
    end

    // Reference store contents as seen by a correct initiator
    logic [31:0] m_val [256];
    bit          m_ok  [256];

    task automatic chk(input string tag, input logic [95:0] got, input logic [95:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic do_cmd(input logic [1:0] op, input logic [7:0] key, input logic [31:0] val,
                          input int busy, input int hold, input bit chk_lat);
        logic [64:0] exp_q [$];
        logic        e_found, e_err;
        logic [31:0] e_val;
        int          base, cbase, lat, n, ncyc;
        e_found = 1'b0;
        e_err   = 1'b0;
        e_val   = 32'h0;
        if (op == 2'd1 || op == 2'd2) begin
            exp_q.push_back({1'b1, BASE, 24'h0, key});
            if (op == 2'd1) exp_q.push_back({1'b1, BASE + 32'h4, val});
            exp_q.push_back({1'b1, BASE + 32'h8, 30'h0, op});
            if (no_ack) begin
                exp_q.delete();
                e_err = 1'b1;
            end else begin
                repeat (stuck ? POLL_MAX : busy + 1) exp_q.push_back({1'b0, BASE + 32'hC, 32'h0});
                if (stuck) e_err = 1'b1;
                else if (op == 2'd2 && m_ok[key]) begin
                    exp_q.push_back({1'b0, BASE + 32'h4, 32'h0});
                    e_found = 1'b1;
                    e_val   = m_val[key];
                end
                if (op == 2'd1) begin
                    m_val[key] = val;
                    m_ok[key]  = 1'b1;
                end
            end
        end else begin
            e_err = 1'b1;
        end
        ncyc = no_ack ? ACK_TMO : exp_q.size();

        busy_n = busy;
        @(negedge clk);
        n = 0;
        while (!cmd_ready && n < 100) begin @(negedge clk); n++; end
        chk("cmd_ready_idle", cmd_ready, 1'b1);
        base  = log_q.size();
        cbase = cyc_cnt;
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_key   = key;
        cmd_val   = val;
        @(negedge clk);
        cmd_valid = 1'b0;
        cmd_op    = 2'($urandom);
        cmd_key   = 8'($urandom);
        cmd_val   = $urandom;
        lat = 1;
        while (!rsp_valid && lat < 3000) begin @(negedge clk); lat++; end
        chk("rsp_arrives", rsp_valid, 1'b1);
        if (chk_lat) chk("put_latency", lat, 9);
        chk("rsp_fields", {rsp_found, rsp_err, rsp_val, cmd_ready}, {e_found, e_err, e_val, 1'b0});
        repeat (hold) begin
            @(negedge clk);
            chk("rsp_hold", {rsp_valid, rsp_found, rsp_err, rsp_val, cmd_ready},
                {1'b1, e_found, e_err, e_val, 1'b0});
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        chk("rsp_done", {rsp_valid, cmd_ready}, {1'b0, 1'b1});
        chk("bus_count", log_q.size() - base, exp_q.size());
        foreach (exp_q[i])
            if (base + i < log_q.size()) chk("bus_xact", log_q[base + i], exp_q[i]);
        chk("cyc_cycles", cyc_cnt - cbase, ncyc);
    endtask

    initial begin
        int n;
        bit seen;
        logic [1:0] op;
        int r;

        repeat (3) @(negedge clk);
        chk("reset_state",
            {cmd_ready, rsp_valid, rsp_found, rsp_err, rsp_val, bus.wbm_cyc_o, bus.wbm_stb_o,
             bus.wbm_we_o, bus.wbm_sel_o, bus.wbm_adr_o, bus.wbm_dat_o},
            {1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0});
        rst = 1'b0;

        do_cmd(2'd1, 8'h2A, 32'hDEADBEEF, 0, 0, 1'b1);
        do_cmd(2'd2, 8'h2A, 32'h0, 2, 0, 1'b0);
        do_cmd(2'd2, 8'h55, 32'h0, 0, 0, 1'b0);

        no_ack = 1'b1;
        do_cmd(2'd1, 8'h11, 32'h12345678, 0, 0, 1'b0);
        no_ack = 1'b0;
        do_cmd(2'd2, 8'h2A, 32'h0, 1, 0, 1'b0);

        stuck = 1'b1;
        do_cmd(2'd2, 8'h2A, 32'h0, 0, 0, 1'b0);
        stuck = 1'b0;
        do_cmd(2'd3, 8'h2A, 32'h0, 0, 0, 1'b0);
        do_cmd(2'd1, 8'h07, 32'hCAFE_F00D, 0, 5, 1'b0);

        // Acks without a cycle must be ignored
        @(negedge clk);
        stray = 1'b1;
        repeat (2) @(negedge clk);
        stray = 1'b0;
        chk("stray_ack", {bus.wbm_cyc_o, rsp_valid, cmd_ready}, {1'b0, 1'b0, 1'b1});

        // Reset while a STATUS read is on the bus
        stuck = 1'b1;
        @(negedge clk);
        cmd_valid = 1'b1;
        cmd_op    = 2'd2;
        cmd_key   = 8'h2A;
        @(negedge clk);
        cmd_valid = 1'b0;
        n = 0;
        while (!(bus.wbm_stb_o && !bus.wbm_we_o && bus.wbm_adr_o == BASE + 32'hC) && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("rst_reach_stat", bus.wbm_stb_o, 1'b1);
        rst = 1'b1;
        @(negedge clk);
        chk("rst_mid_op", {bus.wbm_cyc_o, bus.wbm_stb_o, rsp_valid, cmd_ready},
            {1'b0, 1'b0, 1'b0, 1'b1});
        rst   = 1'b0;
        stuck = 1'b0;
        seen  = 1'b0;
        repeat (20) begin
            @(negedge clk);
            if (rsp_valid || bus.wbm_cyc_o) seen = 1'b1;
        end
        chk("rst_no_rsp", seen, 1'b0);

        for (int i = 0; i < 24; i++) begin
            r  = int'($urandom_range(0, 9));
            op = (r == 0) ? 2'd0 : (r == 1) ? 2'd3 : (r < 6) ? 2'd1 : 2'd2;
            do_cmd(op, 8'($urandom_range(0, 7)), $urandom, int'($urandom_range(0, 3)),
                   int'($urandom_range(0, 3)), 1'b0);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule
